// File: rtl/cpu_io_port.sv
// Peripheral endpoint of the CPU programmed-I/O interface: input FIFO feeding R_IN/FI,
// output holding register plus FIFO draining R_OUT/FO, sticky overrun and gated interrupt.
module cpu_io_port #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ext_in_valid,
    input  logic [WIDTH-1:0] ext_in_data,
    output logic             ext_in_ready,
    output logic [WIDTH-1:0] r_in,
    output logic             fi,
    input  logic             cpu_in_ack,
    input  logic [WIDTH-1:0] r_out,
    input  logic             cpu_out_strobe,
    output logic             fo,
    output logic             ext_out_valid,
    output logic [WIDTH-1:0] ext_out_data,
    input  logic             ext_out_ready,
    input  logic             int_en,
    output logic             irq,
    output logic             overrun,
    input  logic             ovr_clr
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] in_mem_q  [DEPTH];
    logic [WIDTH-1:0] in_mem_d  [DEPTH];
    logic [WIDTH-1:0] out_mem_q [DEPTH];
    logic [WIDTH-1:0] out_mem_d [DEPTH];
    logic [PW-1:0]    in_wp_q, in_wp_d, in_rp_q, in_rp_d;
    logic [PW-1:0]    out_wp_q, out_wp_d, out_rp_q, out_rp_d;
    logic [PW:0]      in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
    logic [WIDTH-1:0] r_in_q, r_in_d, hold_q, hold_d;
    logic             fi_q, fi_d, fo_q, fo_d;
    logic             overrun_q, overrun_d, irq_q, irq_d;

    logic in_full, in_push, in_pop;
    logic out_full, drain, capture, out_pop;

    function automatic logic [PW:0] cnt_next(input logic [PW:0] cnt, input logic inc,
                                             input logic dec);
        logic [PW:0] r;
        r = cnt;
        if (inc && !dec)
            r = cnt + (PW+1)'(1);
        else if (dec && !inc)
            r = cnt - (PW+1)'(1);
        return r;
    endfunction

    always_comb begin
        in_full  = (in_cnt_q == FULL_CNT);
        in_push  = ext_in_valid & ~in_full;
        // The load decision uses the registered count, so a word pushed this cycle waits a cycle.
        in_pop   = (in_cnt_q != '0) & (~fi_q | cpu_in_ack);

        in_mem_d = in_mem_q;
        if (in_push)
            in_mem_d[in_wp_q] = ext_in_data;
        in_wp_d  = in_push ? in_wp_q + PW'(1) : in_wp_q;
        in_rp_d  = in_pop  ? in_rp_q + PW'(1) : in_rp_q;
        in_cnt_d = cnt_next(in_cnt_q, in_push, in_pop);

        r_in_d = r_in_q;
        fi_d   = fi_q;
        if (in_pop) begin
            r_in_d = in_mem_q[in_rp_q];
            fi_d   = 1'b1;
        end else if (cpu_in_ack) begin
            fi_d   = 1'b0;
        end
    end

    always_comb begin
        out_full  = (out_cnt_q == FULL_CNT);
        drain     = fo_q & ~out_full;
        capture   = cpu_out_strobe & (~fo_q | drain);
        out_pop   = (out_cnt_q != '0) & ext_out_ready;

        out_mem_d = out_mem_q;
        if (drain)
            out_mem_d[out_wp_q] = hold_q;
        out_wp_d  = drain   ? out_wp_q + PW'(1) : out_wp_q;
        out_rp_d  = out_pop ? out_rp_q + PW'(1) : out_rp_q;
        out_cnt_d = cnt_next(out_cnt_q, drain, out_pop);

        hold_d    = capture ? r_out : hold_q;
        fo_d      = capture | (fo_q & ~drain);
        // A clear and a fresh drop in the same cycle leave the flag set.
        overrun_d = (overrun_q & ~ovr_clr) | (cpu_out_strobe & fo_q & ~drain);
        irq_d     = int_en & (fi_q | overrun_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                in_mem_q[i]  <= '0;
                out_mem_q[i] <= '0;
            end
            in_wp_q   <= '0;
            in_rp_q   <= '0;
            in_cnt_q  <= '0;
            out_wp_q  <= '0;
            out_rp_q  <= '0;
            out_cnt_q <= '0;
            r_in_q    <= '0;
            hold_q    <= '0;
            fi_q      <= 1'b0;
            fo_q      <= 1'b0;
            overrun_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            in_mem_q  <= in_mem_d;
            out_mem_q <= out_mem_d;
            in_wp_q   <= in_wp_d;
            in_rp_q   <= in_rp_d;
            in_cnt_q  <= in_cnt_d;
            out_wp_q  <= out_wp_d;
            out_rp_q  <= out_rp_d;
            out_cnt_q <= out_cnt_d;
            r_in_q    <= r_in_d;
            hold_q    <= hold_d;
            fi_q      <= fi_d;
            fo_q      <= fo_d;
            overrun_q <= overrun_d;
            irq_q     <= irq_d;
        end
    end

    assign ext_in_ready  = ~in_full;
    assign r_in          = r_in_q;
    assign fi            = fi_q;
    assign fo            = fo_q;
    assign ext_out_valid = (out_cnt_q != '0);
    assign ext_out_data  = out_mem_q[out_rp_q];
    assign irq           = irq_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_cpu_io_port.sv
// Directed bench for cpu_io_port: queue scoreboards for both data paths plus flag and irq timing.
module tb_cpu_io_port;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             ext_in_valid;
    logic [WIDTH-1:0] ext_in_data;
    logic             ext_in_ready;
    logic [WIDTH-1:0] r_in;
    logic             fi;
    logic             cpu_in_ack;
    logic [WIDTH-1:0] r_out;
    logic             cpu_out_strobe;
    logic             fo;
    logic             ext_out_valid;
    logic [WIDTH-1:0] ext_out_data;
    logic             ext_out_ready;
    logic             int_en;
    logic             irq;
    logic             overrun;
    logic             ovr_clr;

    cpu_io_port #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .ext_in_valid(ext_in_valid), .ext_in_data(ext_in_data), .ext_in_ready(ext_in_ready),
        .r_in(r_in), .fi(fi), .cpu_in_ack(cpu_in_ack),
        .r_out(r_out), .cpu_out_strobe(cpu_out_strobe), .fo(fo),
        .ext_out_valid(ext_out_valid), .ext_out_data(ext_out_data), .ext_out_ready(ext_out_ready),
        .int_en(int_en), .irq(irq), .overrun(overrun), .ovr_clr(ovr_clr)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [WIDTH-1:0] in_q[$];
    logic [WIDTH-1:0] out_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_fi"},        32'(fi), 0);
        chk({tag, "_fo"},        32'(fo), 0);
        chk({tag, "_irq"},       32'(irq), 0);
        chk({tag, "_overrun"},   32'(overrun), 0);
        chk({tag, "_r_in"},      r_in, 0);
        chk({tag, "_out_valid"}, 32'(ext_out_valid), 0);
        chk({tag, "_out_data"},  ext_out_data, 0);
        chk({tag, "_in_ready"},  32'(ext_in_ready), 1);
    endtask

    task automatic drain_out(input string tag);
        logic [WIDTH-1:0] e;
        for (int k = 0; k < 40 && out_q.size() > 0; k++) begin
            if (ext_out_valid) begin
                e = out_q.pop_front();
                chk(tag, ext_out_data, e);
            end
            tick();
        end
        chk({tag, "_all_seen"}, 32'(out_q.size()), 0);
    endtask

    initial begin
        bit m_fo;
        int m_cnt;
        bit ovr_exp;
        bit drn;

        rst = 1'b1;
        ext_in_valid = 1'b0; ext_in_data = '0; cpu_in_ack = 1'b0;
        r_out = '0; cpu_out_strobe = 1'b0; ext_out_ready = 1'b0;
        int_en = 1'b0; ovr_clr = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk_reset("rst0");

        // Three pushes, then acks step through them.
        ext_in_valid = 1'b1; ext_in_data = 32'h11; in_q.push_back(ext_in_data);
        tick();
        chk("fi_not_yet", 32'(fi), 0);
        ext_in_data = 32'h22; in_q.push_back(ext_in_data);
        tick();
        chk("fi_rise", 32'(fi), 1);
        chk("r_in_first", r_in, in_q.pop_front());
        ext_in_data = 32'h33; in_q.push_back(ext_in_data);
        tick();
        ext_in_valid = 1'b0;
        chk("r_in_hold_no_ack", r_in, 32'h11);
        cpu_in_ack = 1'b1;
        tick();
        chk("r_in_ack1", r_in, in_q.pop_front());
        tick();
        chk("r_in_ack2", r_in, in_q.pop_front());
        tick();
        cpu_in_ack = 1'b0;
        chk("fi_clear_empty", 32'(fi), 0);
        chk("r_in_keep", r_in, 32'h33);

        // Fill the input FIFO behind an unread r_in.
        ext_in_valid = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) begin
            ext_in_data = 32'h40 + 32'(i);
            if (ext_in_ready) in_q.push_back(ext_in_data);
            tick();
        end
        ext_in_valid = 1'b0;
        chk("in_full_ready", 32'(ext_in_ready), 0);
        chk("in_accepted", 32'(in_q.size()), DEPTH + 1);
        chk("r_in_fill_head", r_in, in_q.pop_front());
        cpu_in_ack = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            chk("r_in_b2b", r_in, in_q.pop_front());
            chk("fi_b2b", 32'(fi), 1);
        end
        chk("in_ready_after", 32'(ext_in_ready), 1);
        tick();
        cpu_in_ack = 1'b0;
        chk("fi_after_drain", 32'(fi), 0);

        // Output path overflow with the consumer stalled.
        ext_out_ready = 1'b0;
        m_fo = 1'b0; m_cnt = 0; ovr_exp = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            r_out = 32'hA0 + 32'(i);
            cpu_out_strobe = 1'b1;
            drn = m_fo && (m_cnt < DEPTH);
            if (drn) m_cnt++;
            if (!m_fo || drn) begin
                out_q.push_back(r_out);
                m_fo = 1'b1;
            end else begin
                ovr_exp = 1'b1;
            end
            tick();
        end
        cpu_out_strobe = 1'b0;
        chk("fo_held", 32'(fo), 1);
        chk("overrun_set", 32'(overrun), 32'(ovr_exp));
        chk("out_valid_full", 32'(ext_out_valid), 1);
        chk("out_head_stall", ext_out_data, out_q[0]);
        tick();
        chk("out_head_steady", ext_out_data, out_q[0]);
        ext_out_ready = 1'b1;
        drain_out("out_seq");
        chk("fo_drained", 32'(fo), 0);
        chk("out_valid_empty", 32'(ext_out_valid), 0);

        // Clear overrun, then strobe in the same cycle as a drain.
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        chk("ovr_cleared", 32'(overrun), 0);
        r_out = 32'hB0; cpu_out_strobe = 1'b1; out_q.push_back(r_out);
        tick();
        chk("fo_strobe", 32'(fo), 1);
        r_out = 32'hB1; out_q.push_back(r_out);
        tick();
        cpu_out_strobe = 1'b0;
        chk("fo_drain_capture", 32'(fo), 1);
        chk("ovr_drain_capture", 32'(overrun), 0);
        drain_out("out_b2b");

        // Interrupt timing.
        int_en = 1'b1;
        ext_in_valid = 1'b1; ext_in_data = 32'hC0;
        tick();
        ext_in_valid = 1'b0;
        tick();
        chk("fi_for_irq", 32'(fi), 1);
        chk("irq_lag", 32'(irq), 0);
        tick();
        chk("irq_rise", 32'(irq), 1);
        int_en = 1'b0;
        tick();
        chk("irq_fall", 32'(irq), 0);

        // Overrun set wins over a simultaneous clear.
        ext_out_ready = 1'b0;
        for (int i = 0; i <= DEPTH; i++) begin
            r_out = 32'hD0 + 32'(i); cpu_out_strobe = 1'b1;
            tick();
        end
        r_out = 32'hDF; ovr_clr = 1'b1;
        tick();
        cpu_out_strobe = 1'b0; ovr_clr = 1'b0;
        chk("ovr_set_wins", 32'(overrun), 1);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        chk("ovr_clr_alone", 32'(overrun), 0);

        // Reset with both FIFOs holding data.
        ext_in_valid = 1'b1; ext_in_data = 32'hE0;
        tick();
        ext_in_data = 32'hE1;
        tick();
        ext_in_valid = 1'b0;
        chk("out_valid_prereset", 32'(ext_out_valid), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset("rst_mid");
        in_q.delete();
        out_q.delete();

        ext_in_valid = 1'b1; ext_in_data = 32'hF0;
        tick();
        ext_in_valid = 1'b0;
        tick();
        chk("post_rst_fi", 32'(fi), 1);
        chk("post_rst_r_in", r_in, 32'hF0);
        r_out = 32'h77; cpu_out_strobe = 1'b1;
        tick();
        cpu_out_strobe = 1'b0;
        chk("post_rst_fo", 32'(fo), 1);
        chk("post_rst_no_stale", 32'(ext_out_valid), 0);
        tick();
        chk("post_rst_out_valid", 32'(ext_out_valid), 1);
        chk("post_rst_out_data", ext_out_data, 32'h77);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
